ym3438_detune_pipe: RTL and testbench



---
 rtl/ym3438_detune_pipe.sv | 169 ++++++++++++++++
 tb/tb_ym3438_detune_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_detune_pipe.sv
// Time-multiplexed FM operator detune: c1 samples a slot into an input latch,
// and each c2 advances a 3-stage pipeline producing the detuned phase increment.
module ym3438_detune_pipe #(
    parameter int SLOTS     = 24,
    parameter int FW        = 17,
    parameter int MAG_SHIFT = 0,
    parameter int DT_SAT    = 0,
    parameter int SW        = 5
) (
    input  logic          MCLK,
    input  logic          reset_n,
    input  logic          c1,
    input  logic          c2,
    input  logic          sync,
    input  logic [2:0]    dt,
    input  logic [4:0]    kcode,
    input  logic [FW-1:0] freq_in,
    output logic [FW-1:0] freq_out,
    output logic [4:0]    dt_mag,
    output logic          dt_neg,
    output logic [SW-1:0] slot_out
);

    typedef struct packed {
        logic [2:0]    dt;
        logic [4:0]    kcode;
        logic [FW-1:0] freq;
        logic          sync;
    } smp_t;

    typedef struct packed {
        logic [2:0]    dt;
        logic [4:0]    kcode;
        logic [FW-1:0] freq;
        logic [SW-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic          neg;
        logic [4:0]    mag;
        logic [FW-1:0] freq;
        logic [SW-1:0] tag;
    } s2_t;

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == SW'(SLOTS - 1)) ? '0 : s + 1'b1;
    endfunction

    // c2 has priority: a c1 coinciding with c2 is dropped.
    logic cap, adv;
    assign adv = c2;
    assign cap = c1 & ~c2;

    smp_t          in_q;
    s1_t           s1_q;
    s2_t           s2_q;
    logic [SW-1:0] slot_cnt;
    logic [SW-1:0] tag_now;

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= '0;
        end else if (cap) begin
            in_q.dt    <= dt;
            in_q.kcode <= kcode;
            in_q.freq  <= freq_in;
            in_q.sync  <= sync;
        end
    end

    // A latched sync tags this slot as 0 and the counter carries on from 1.
    assign tag_now = in_q.sync ? '0 : slot_cnt;

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            slot_cnt <= '0;
        end else if (adv) begin
            s1_q.dt    <= in_q.dt;
            s1_q.kcode <= in_q.kcode;
            s1_q.freq  <= in_q.freq;
            s1_q.tag   <= tag_now;
            slot_cnt   <= slot_inc(tag_now);
        end
    end

    // Stage 2: detune magnitude from DT amount and key code
    logic       amt_nz;
    logic [4:0] s5;
    logic [1:0] lo2;
    logic [3:0] sh;
    logic [2:0] idx;
    logic [3:0] m;
    logic [4:0] mag_full;
    logic [4:0] mag_c;

    always_comb begin
        amt_nz   = s1_q.dt[1] | s1_q.dt[0];
        s5       = 5'd1
                 + {1'b0, amt_nz, 1'b0, s1_q.dt[1], s1_q.dt[1] & s1_q.dt[0]}
                 + {2'b00, s1_q.kcode[4:2]};
        lo2      = (s1_q.kcode[4:2] == 3'd7) ? 2'd0 : s1_q.kcode[1:0];
        sh       = s5[4:1];
        idx      = {s5[0], lo2};
        m        = 4'd0;
        case (idx)
            3'd0: m = 4'd0;
            3'd1: m = 4'd1;
            3'd2: m = 4'd3;
            3'd3: m = 4'd4;
            3'd4: m = 4'd6;
            3'd5: m = 4'd8;
            3'd6: m = 4'd11;
            3'd7: m = 4'd13;
            default: m = 4'd0;
        endcase
        mag_full = {1'b1, m};
        mag_c    = 5'd0;
        if (amt_nz && sh >= 4'd5 && sh <= 4'd9)
            mag_c = mag_full >> (4'd9 - sh);
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            s2_q <= '0;
        end else if (adv) begin
            s2_q.neg  <= s1_q.dt[2];
            s2_q.mag  <= mag_c;
            s2_q.freq <= s1_q.freq;
            s2_q.tag  <= s1_q.tag;
        end
    end

    // Stage 3: apply scaled detune, wrapping or clamping on negative underflow
    logic [FW-1:0] d_ext;
    logic [FW-1:0] sum_w;
    logic [FW-1:0] diff_w;
    logic          under;
    logic [FW-1:0] res;

    always_comb begin
        d_ext  = {{(FW-5){1'b0}}, s2_q.mag} << MAG_SHIFT;
        sum_w  = s2_q.freq + d_ext;
        diff_w = s2_q.freq - d_ext;
        under  = s2_q.freq < d_ext;
        res    = sum_w;
        if (s2_q.neg) begin
            if ((DT_SAT != 0) && under)
                res = '0;
            else
                res = diff_w;
        end
    end

    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            freq_out <= '0;
            dt_mag   <= '0;
            dt_neg   <= 1'b0;
            slot_out <= '0;
        end else if (adv) begin
            freq_out <= res;
            dt_mag   <= s2_q.mag;
            dt_neg   <= s2_q.neg & (s2_q.mag != 5'd0);
            slot_out <= s2_q.tag;
        end
    end

endmodule

// File: tb/tb_ym3438_detune_pipe.sv
// Scoreboard bench for ym3438_detune_pipe: three instances (wrap, clamp, x4 scale)
// share one stimulus stream; expectations come from an arithmetic model or literals.
module tb_ym3438_detune_pipe;

    localparam int FMOD = 131072;

    typedef struct {
        logic [16:0] f0;
        logic [16:0] f1;
        logic [16:0] f2;
        logic [4:0]  mag;
        logic        neg;
        logic [4:0]  slot;
    } exp_t;

    logic        MCLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        c1 = 1'b0, c2 = 1'b0, sync = 1'b0;
    logic [2:0]  dt = '0;
    logic [4:0]  kcode = '0;
    logic [16:0] freq_in = '0;

    logic [16:0] fo0, fo1, fo2;
    logic [4:0]  mg0, mg1, mg2;
    logic        ng0, ng1, ng2;
    logic [4:0]  so0, so1, so2;

    int   n_vec = 0;
    int   n_err = 0;
    int   slot_m = 0;
    exp_t sbq[$];
    exp_t mon_e;
    exp_t last_e;
    logic c2_hit = 1'b0;

    always #5 MCLK = ~MCLK;

    ym3438_detune_pipe u0 (
        .MCLK(MCLK), .reset_n(reset_n), .c1(c1), .c2(c2), .sync(sync),
        .dt(dt), .kcode(kcode), .freq_in(freq_in),
        .freq_out(fo0), .dt_mag(mg0), .dt_neg(ng0), .slot_out(so0)
    );

    ym3438_detune_pipe #(.DT_SAT(1)) u1 (
        .MCLK(MCLK), .reset_n(reset_n), .c1(c1), .c2(c2), .sync(sync),
        .dt(dt), .kcode(kcode), .freq_in(freq_in),
        .freq_out(fo1), .dt_mag(mg1), .dt_neg(ng1), .slot_out(so1)
    );

    ym3438_detune_pipe #(.MAG_SHIFT(2)) u2 (
        .MCLK(MCLK), .reset_n(reset_n), .c1(c1), .c2(c2), .sync(sync),
        .dt(dt), .kcode(kcode), .freq_in(freq_in),
        .freq_out(fo2), .dt_mag(mg2), .dt_neg(ng2), .slot_out(so2)
    );

    function automatic exp_t model(input logic [2:0] d, input logic [4:0] k, input logic [16:0] fi);
        exp_t e;
        int   mt[8];
        int   a, s, lo, sh, idx, mag, fiv, m4;
        mt  = '{0, 1, 3, 4, 6, 8, 11, 13};
        a   = (d[1:0] != 2'b00) ? 1 : 0;
        s   = 1 + 8 * a + (d[1] ? 2 : 0) + ((d[1:0] == 2'b11) ? 1 : 0) + int'(k[4:2]);
        lo  = (k[4:2] == 3'd7) ? 0 : int'(k[1:0]);
        sh  = s / 2;
        idx = (s % 2) * 4 + lo;
        mag = (a == 1 && sh >= 5 && sh <= 9) ? ((16 + mt[idx]) >> (9 - sh)) : 0;
        fiv = int'(fi);
        m4  = mag * 4;
        if (d[2]) begin
            e.f0 = 17'((fiv - mag + FMOD) % FMOD);
            e.f1 = (fiv >= mag) ? 17'(fiv - mag) : 17'd0;
            e.f2 = 17'((fiv - m4 + FMOD) % FMOD);
        end else begin
            e.f0 = 17'((fiv + mag) % FMOD);
            e.f1 = 17'((fiv + mag) % FMOD);
            e.f2 = 17'((fiv + m4) % FMOD);
        end
        e.mag  = 5'(mag);
        e.neg  = d[2] && (mag != 0);
        e.slot = 5'd0;
        return e;
    endfunction

    // Scoreboard: a result is due after each c2 once three samples are in flight.
    always @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) c2_hit <= 1'b0;
        else          c2_hit <= c2;
    end

    always @(negedge MCLK) begin
        if (c2_hit && sbq.size() >= 3) begin
            mon_e = sbq.pop_front();
            n_vec += 6;
            if (fo0 !== mon_e.f0) begin
                n_err++; $display("FAIL sb_freq_wrap slot %0d: got %h want %h", mon_e.slot, fo0, mon_e.f0);
            end
            if (fo1 !== mon_e.f1) begin
                n_err++; $display("FAIL sb_freq_sat slot %0d: got %h want %h", mon_e.slot, fo1, mon_e.f1);
            end
            if (fo2 !== mon_e.f2) begin
                n_err++; $display("FAIL sb_freq_shift slot %0d: got %h want %h", mon_e.slot, fo2, mon_e.f2);
            end
            if (mg0 !== mon_e.mag) begin
                n_err++; $display("FAIL sb_dt_mag slot %0d: got %0d want %0d", mon_e.slot, mg0, mon_e.mag);
            end
            if (ng0 !== mon_e.neg) begin
                n_err++; $display("FAIL sb_dt_neg slot %0d: got %b want %b", mon_e.slot, ng0, mon_e.neg);
            end
            if (so0 !== mon_e.slot) begin
                n_err++; $display("FAIL sb_slot_out: got %0d want %0d", so0, mon_e.slot);
            end
            last_e = mon_e;
        end
    end

    task automatic drive(input logic [2:0] d, input logic [4:0] k, input logic [16:0] fi,
                         input logic sy, input logic both, input exp_t e_in);
        exp_t e;
        e      = e_in;
        e.slot = sy ? 5'd0 : 5'(slot_m);
        slot_m = sy ? 1 : (slot_m + 1) % 24;
        sbq.push_back(e);
        @(negedge MCLK); #1;
        dt = d; kcode = k; freq_in = fi; sync = sy; c1 = 1'b1; c2 = 1'b0;
        @(negedge MCLK); #1;
        c1 = both; c2 = 1'b1;
        if (both) begin
            dt = ~d; kcode = ~k; freq_in = ~fi; sync = ~sy;
        end
        @(negedge MCLK); #1;
        c1 = 1'b0; c2 = 1'b0; sync = 1'b0;
    endtask

    task automatic pair(input logic [2:0] d, input logic [4:0] k, input logic [16:0] fi, input logic sy);
        drive(d, k, fi, sy, 1'b0, model(d, k, fi));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_vec += 4;
        if (fo0 !== 17'd0) begin n_err++; $display("FAIL reset_freq: got %h want 0", fo0); end
        if (mg0 !== 5'd0)  begin n_err++; $display("FAIL reset_mag: got %0d want 0", mg0); end
        if (ng0 !== 1'b0)  begin n_err++; $display("FAIL reset_neg: got %b want 0", ng0); end
        if (so0 !== 5'd0)  begin n_err++; $display("FAIL reset_slot: got %0d want 0", so0); end
        @(negedge MCLK); #1;
        reset_n = 1'b1;
        slot_m = 0;
    endtask

    task automatic test_mag_table();
        logic [2:0]  dts[4]  = '{3'd1, 3'd2, 3'd3, 3'd1};
        logic [4:0]  kcs[4]  = '{5'd31, 5'd31, 5'd31, 5'd0};
        logic [4:0]  mags[4] = '{5'd8, 5'd16, 5'd22, 5'd0};
        logic [16:0] fos[4]  = '{17'd1008, 17'd1016, 17'd1022, 17'd1000};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = model(dts[i], kcs[i], 17'd1000);
            e.mag = mags[i];
            e.f0  = fos[i];
            drive(dts[i], kcs[i], 17'd1000, 1'b0, 1'b0, e);
        end
        for (int k = 0; k < 32; k += 3)
            for (int d = 0; d < 8; d++)
                pair(3'(d), 5'(k), 17'(1000 + 7 * k), 1'b0);
    endtask

    task automatic test_sign_wrap();
        exp_t e;
        e = model(3'd5, 5'd31, 17'd5);
        e.f0 = 17'h1FFFD; e.f1 = 17'd0; e.neg = 1'b1;
        drive(3'd5, 5'd31, 17'd5, 1'b0, 1'b0, e);
        for (int k = 0; k < 32; k += 13) begin
            e = model(3'd4, 5'(k), 17'd777);
            e.mag = 5'd0; e.neg = 1'b0; e.f0 = 17'd777;
            drive(3'd4, 5'(k), 17'd777, 1'b0, 1'b0, e);
        end
        pair(3'd7, 5'd30, 17'd3, 1'b0);
        pair(3'd6, 5'd20, 17'd0, 1'b0);
    endtask

    task automatic test_add_scale();
        exp_t e;
        e = model(3'd3, 5'd31, 17'h1FFFF);
        e.f0 = 17'h15;
        drive(3'd3, 5'd31, 17'h1FFFF, 1'b0, 1'b0, e);
        e = model(3'd3, 5'd31, 17'd0);
        e.f2 = 17'd88;
        drive(3'd3, 5'd31, 17'd0, 1'b0, 1'b0, e);
    endtask

    task automatic test_slot_counter();
        pair(3'd3, 5'd31, 17'd4242, 1'b1);
        for (int i = 0; i < 30; i++)
            pair(3'($urandom_range(7)), 5'($urandom_range(31)), 17'($urandom), 1'b0);
        pair(3'd2, 5'd25, 17'd100, 1'b1);
        for (int i = 0; i < 6; i++)
            pair(3'($urandom_range(7)), 5'($urandom_range(31)), 17'($urandom), 1'b0);
    endtask

    task automatic test_stall();
        for (int p = 0; p < 3; p++) begin
            pair(3'($urandom_range(7)), 5'($urandom_range(16, 31)), 17'($urandom), 1'b0);
            for (int i = 0; i < 10; i++) begin
                @(negedge MCLK); #1;
                dt = 3'($urandom); kcode = 5'($urandom); freq_in = 17'($urandom); sync = 1'b1;
                n_vec += 2;
                if (fo0 !== last_e.f0) begin
                    n_err++; $display("FAIL stall_freq: got %h want %h", fo0, last_e.f0);
                end
                if (so0 !== last_e.slot) begin
                    n_err++; $display("FAIL stall_slot: got %0d want %0d", so0, last_e.slot);
                end
            end
            sync = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            drive(3'd3, 5'(28 + i), 17'(500 * i), 1'b0, 1'b1, model(3'd3, 5'(28 + i), 17'(500 * i)));
        for (int i = 0; i < 3; i++)
            pair(3'd1, 5'd31, 17'(i), 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            pair(3'($urandom_range(7)), 5'($urandom_range(31)), 17'($urandom), i == 17);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            pair(3'd3, 5'd31, 17'(2000 + i), 1'b0);
        @(negedge MCLK); #1;
        dt = 3'd2; kcode = 5'd31; freq_in = 17'd9; c1 = 1'b1;
        @(negedge MCLK); #1;
        c1 = 1'b0;
        reset_n = 1'b0;
        #1;
        n_vec += 4;
        if (fo0 !== 17'd0) begin n_err++; $display("FAIL midreset_freq: got %h want 0", fo0); end
        if (mg0 !== 5'd0)  begin n_err++; $display("FAIL midreset_mag: got %0d want 0", mg0); end
        if (ng0 !== 1'b0)  begin n_err++; $display("FAIL midreset_neg: got %b want 0", ng0); end
        if (so0 !== 5'd0)  begin n_err++; $display("FAIL midreset_slot: got %0d want 0", so0); end
        sbq.delete();
        slot_m = 0;
        @(negedge MCLK); #1;
        reset_n = 1'b1;
        pair(3'd1, 5'd31, 17'd1000, 1'b0);
        n_vec += 2;
        if (fo0 !== 17'd0) begin n_err++; $display("FAIL postreset_early_freq: got %h want 0", fo0); end
        if (mg0 !== 5'd0)  begin n_err++; $display("FAIL postreset_early_mag: got %0d want 0", mg0); end
        pair(3'd2, 5'd31, 17'd1000, 1'b0);
        n_vec++;
        if (fo0 !== 17'd0) begin n_err++; $display("FAIL postreset_early2_freq: got %h want 0", fo0); end
        for (int i = 0; i < 5; i++)
            pair(3'($urandom_range(7)), 5'($urandom_range(31)), 17'($urandom), 1'b0);
    endtask

    initial begin
        test_reset();
        test_mag_table();
        test_sign_wrap();
        test_add_scale();
        test_slot_counter();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge MCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
